i2c_scl_gen: RTL and testbench
==============================

# i2c_scl_gen

Parametrised SCL generator for the I2C master, replacing the fixed four-rate clock block. The SCL period is programmable at run time and re-latched at every SCL period. Explicit start/stop requests frame the clocking, with one-cycle rise/fall strobes for the SDA shifter. Optional clock-stretching detection with timeout is included. The block sits between the APB register file (divisor, control) and the I2C bit/byte controller, in the `pclk` domain.

## Interface
- `DIV_W`, 9: width of divisor and phase counter.
- `STRETCH_MAX`, 1023: maximum consecutive stretch cycles before abort; must fit in 16 bits.

- `pclk` in 1: system clock; all logic on rising edge.
- `prst_n` in 1: reset, synchronous, active-low.
- `i_div` in DIV_W: SCL period in `pclk` cycles; values < 4 are treated as 4.
- `i_start` in 1: one-cycle request to begin clocking; ignored while busy.
- `i_stop` in 1: one-cycle request to finish after the current high phase; ignored in IDLE unless `i_start` is also high.
- `i_scl_in` in 1: bus SCL level, already synchronised upstream.
- `o_scl` out 1: SCL drive level; 1 = release (open-drain high), 0 = pull low.
- `o_busy` out 1: high from the first LOW cycle until return to IDLE.
- `o_fall` out 1: one-cycle strobe, coincident with the first cycle of each LOW phase.
- `o_rise` out 1: one-cycle strobe, coincident with the first cycle of each HIGH phase.
- `o_stretch` out 1: high in HIGH-phase cycles where `i_scl_in` = 0.
- `o_tmo` out 1: one-cycle strobe on stretch-timeout abort.

## Operation
- States: IDLE, LOW, HIGH.
- Period latch: on every entry to LOW, `div_q` = max(`i_div`, 4).
  - H = `div_q` >> 1; L = `div_q` − H.
  - `i_div` changes take effect at the next period only.
- IDLE: `o_scl`=1, `o_busy`=0, phase counter 0, stop_pending 0. `i_start`=1 → LOW.
- LOW: `o_scl`=0. Counter runs 0..L−1; at L−1 → HIGH, counter cleared.
- HIGH: `o_scl`=1.
  - Counter advances only on cycles where `i_scl_in`=1 or stretch support is compiled out.
  - At count H−1 with advance: stop_pending → IDLE; otherwise → LOW.
- Counter arithmetic is DIV_W bits unsigned and never wraps, because it is bounded by L−1 or H−1.
- stop_pending:
  - Set by `i_stop` in LOW or HIGH.
  - Set by `i_stop` coincident with `i_start` in IDLE, which gives exactly one SCL period.
  - Cleared on IDLE entry.
- `i_start` while busy: ignored. `i_stop` while stop_pending is already set: no effect.
- Stretch timeout: a stretch counter increments on each stretched HIGH cycle and clears on any non-stretched cycle. On reaching STRETCH_MAX: `o_tmo` pulses, state → IDLE, stop_pending cleared.
- Reset (`prst_n`=0 at a `pclk` edge), from any state: IDLE, `o_scl`=1, all other outputs 0, counters and stop_pending cleared.

## Timing
- `i_start` sampled at edge T:
  - T+1: `o_scl`=0, `o_fall`=1, `o_busy`=1.
  - `o_scl`=0 through T+L.
  - T+L+1: `o_scl`=1, `o_rise`=1.
  - Unstretched HIGH covers T+L+1..T+L+H.
- Next period: `o_fall` at T+L+H+1. With stop, `o_busy`=0 at T+L+H+1 instead.
- Each stretched cycle delays HIGH exit by exactly one cycle.
- `o_stretch` is combinational on state and `i_scl_in`. All other outputs are registered.
- Outputs are registered-state driven; no combinational path from `i_start`/`i_stop` to outputs.

## Configuration
- `I2C_STRETCH_EN` defined:
  - `i_scl_in` gates the HIGH counter.
  - `o_stretch` and `o_tmo` are live.
  - Stretch counter is present.
- Undefined:
  - `i_scl_in` is ignored.
  - HIGH always lasts H cycles.
  - `o_stretch` = `o_tmo` = 0.
  - Stretch counter is not synthesised.

## Test plan
- Reset: hold `prst_n`=0 for 3 edges mid-run → `o_scl`=1, `o_busy`=`o_rise`=`o_fall`=`o_stretch`=`o_tmo`=0 the cycle after the first low edge.
- Single period: `i_div`=10, `i_start`=`i_stop`=1 at T → `o_fall` at T+1, low T+1..T+5, `o_rise` at T+6, high T+6..T+10, `o_busy`=0 at T+11.
- Clamp/odd:
  - `i_div`=3 → L=2, H=2.
  - `i_div`=7 → L=4, H=3.
  - `i_div` changed from 10 to 20 mid-LOW → current period 10, next 20.
- Stretch (macro on): `i_div`=10, `i_scl_in`=0 for 8 cycles from `o_rise` → HIGH lasts 13 cycles, `o_stretch` high 8 cycles, no `o_tmo`.
- Timeout (macro on, STRETCH_MAX=16): `i_scl_in` held 0 → `o_tmo` pulse on the 16th stretched cycle, then IDLE with `o_scl`=1; macro off → same stimulus gives normal 5-cycle HIGH.
- Continuous run: `i_div`=8, start, `i_stop` after the 3rd `o_rise` → exactly 3 `o_fall` and 3 `o_rise` strobes, `o_busy` drops at the end of the 3rd HIGH; `i_start` pulses while busy are ignored.

Source files
------------

// File: rtl/i2c_scl_gen.sv
// I2C SCL generator: run-time programmable period, start/stop framing, rise/fall strobes.
// Define I2C_STRETCH_EN to add clock-stretch detection with a stretch timeout.
module i2c_scl_gen #(
  parameter int DIV_W       = 9,
  parameter int STRETCH_MAX = 1023
) (
  input  logic             pclk,
  input  logic             prst_n,
  input  logic [DIV_W-1:0] i_div,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_scl_in,
  output logic             o_scl,
  output logic             o_busy,
  output logic             o_fall,
  output logic             o_rise,
  output logic             o_stretch,
  output logic             o_tmo
);
  // state | meaning
  // IDLE  | SCL released, waiting for a start request
  // LOW   | SCL pulled low for L = div_q - H cycles
  // HIGH  | SCL released until H advancing cycles have elapsed
  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH} state_t;

  state_t           state, state_nx;
  logic [DIV_W-1:0] div_q, div_clamp, half_h, half_l, cnt;
  logic             stop_pend;
  logic             stretched, tmo_hit, low_done, high_done;
  logic             scl_nx, busy_nx, fall_nx, rise_nx, tmo_nx;

  assign div_clamp = (i_div < DIV_W'(4)) ? DIV_W'(4) : i_div;
  assign half_h    = div_q >> 1;
  assign half_l    = div_q - half_h;
  assign low_done  = (state == S_LOW) && (cnt == half_l - DIV_W'(1));
  assign high_done = (state == S_HIGH) && !stretched && (cnt == half_h - DIV_W'(1));

`ifdef I2C_STRETCH_EN
  logic [15:0] str_cnt;

  assign stretched = (state == S_HIGH) && !i_scl_in;
  assign tmo_hit   = stretched && (str_cnt == 16'(STRETCH_MAX - 1));

  always_ff @(posedge pclk) begin
    if (!prst_n)
      str_cnt <= '0;
    else if (stretched && !tmo_hit)
      str_cnt <= str_cnt + 16'd1;
    else
      str_cnt <= '0;
  end
`else
  logic unused_scl_in;

  assign unused_scl_in = i_scl_in;
  assign stretched     = 1'b0;
  assign tmo_hit       = 1'b0;
`endif

  assign o_stretch = stretched;

  always_ff @(posedge pclk) begin
    if (!prst_n) begin
      state  <= S_IDLE;
      o_scl  <= 1'b1;
      o_busy <= 1'b0;
      o_fall <= 1'b0;
      o_rise <= 1'b0;
      o_tmo  <= 1'b0;
    end else begin
      state  <= state_nx;
      o_scl  <= scl_nx;
      o_busy <= busy_nx;
      o_fall <= fall_nx;
      o_rise <= rise_nx;
      o_tmo  <= tmo_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (i_start) state_nx = S_LOW;
      S_LOW:   if (low_done) state_nx = S_HIGH;
      S_HIGH: begin
        if (tmo_hit)
          state_nx = S_IDLE;
        else if (high_done)
          state_nx = stop_pend ? S_IDLE : S_LOW;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    scl_nx  = (state_nx != S_LOW);
    busy_nx = (state_nx != S_IDLE);
    fall_nx = (state_nx == S_LOW) && (state != S_LOW);
    rise_nx = (state_nx == S_HIGH) && (state == S_LOW);
    tmo_nx  = tmo_hit;
  end

  // Period is latched only on LOW entry so i_div changes land on the next period.
  always_ff @(posedge pclk) begin
    if (!prst_n) begin
      cnt       <= '0;
      div_q     <= DIV_W'(4);
      stop_pend <= 1'b0;
    end else begin
      if (state_nx != state)
        cnt <= '0;
      else if (state == S_LOW || (state == S_HIGH && !stretched))
        cnt <= cnt + DIV_W'(1);

      if (state_nx == S_LOW && state != S_LOW)
        div_q <= div_clamp;

      if (state_nx == S_IDLE)
        stop_pend <= 1'b0;
      else if (i_stop && (state != S_IDLE || i_start))
        stop_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_i2c_scl_gen.sv
// Self-checking bench for i2c_scl_gen: directed and random traces against a per-period reference.
// Expected waveforms are built period by period from the L/H/stop/stretch rules.
module tb_i2c_scl_gen;
  localparam int DIV_W = 9;
  localparam int SMAX  = 16;
  localparam int MAXN  = 400;
`ifdef I2C_STRETCH_EN
  localparam bit STR_EN = 1'b1;
`else
  localparam bit STR_EN = 1'b0;
`endif

  logic             pclk, prst_n;
  logic [DIV_W-1:0] i_div;
  logic             i_start, i_stop, i_scl_in;
  logic             o_scl, o_busy, o_fall, o_rise, o_stretch, o_tmo;

  int n_cmp = 0;
  int n_err = 0;

  // stimulus per cycle, expected/observed {scl,busy,fall,rise,stretch,tmo} per cycle
  int         s_div   [MAXN];
  bit         s_start [MAXN];
  bit         s_stop  [MAXN];
  bit         s_scl   [MAXN];
  logic [5:0] e_v     [MAXN];
  logic [5:0] obs_v   [MAXN];
  int obs_falls, obs_rises, obs_str, obs_tmo;

  i2c_scl_gen #(.DIV_W(DIV_W), .STRETCH_MAX(SMAX)) dut (
    .pclk(pclk), .prst_n(prst_n), .i_div(i_div), .i_start(i_start), .i_stop(i_stop),
    .i_scl_in(i_scl_in), .o_scl(o_scl), .o_busy(o_busy), .o_fall(o_fall),
    .o_rise(o_rise), .o_stretch(o_stretch), .o_tmo(o_tmo)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  function automatic void clear_stim(input int div);
    for (int k = 0; k < MAXN; k++) begin
      s_div[k] = div; s_start[k] = 1'b0; s_stop[k] = 1'b0; s_scl[k] = 1'b1;
    end
  endfunction

  // Reference: walk whole SCL periods; only the HIGH phase needs cycle detail (stretching).
  function automatic void build_expected(input int n);
    int c, p, c2, d, hh, ll, adv, run, outcome;
    bit stop_p, in_run;
    for (int k = 0; k < MAXN; k++) e_v[k] = 6'b100000;
    c = 0;
    while (c < n) begin
      if (!s_start[c]) begin c++; continue; end
      stop_p = s_stop[c];
      p = c + 1;
      in_run = 1'b1;
      while (in_run) begin
        d  = (s_div[p-1] < 4) ? 4 : s_div[p-1];
        hh = d / 2;
        ll = d - hh;
        for (int i = 0; i < ll; i++) begin
          e_v[p+i] = 6'b010000 | ((i == 0) ? 6'b001000 : 6'b000000);
          stop_p |= s_stop[p+i];
        end
        c2 = p + ll; adv = 0; run = 0; outcome = 0;
        while (c2 < n && outcome == 0) begin
          e_v[c2] = 6'b110000 | ((c2 == p + ll) ? 6'b000100 : 6'b000000);
          if (STR_EN && !s_scl[c2]) begin
            e_v[c2] |= 6'b000010;
            run++;
            if (run == SMAX) outcome = 2;
          end else begin
            run = 0;
            adv++;
            if (adv == hh) outcome = 1;
          end
          if (outcome == 0) begin stop_p |= s_stop[c2]; c2++; end
        end
        if (outcome == 0) begin
          c = n; in_run = 1'b0;
        end else if (outcome == 2) begin
          e_v[c2+1] = 6'b100001; stop_p = 1'b0; c = c2 + 1; in_run = 1'b0;
        end else if (stop_p) begin
          stop_p = 1'b0; c = c2 + 1; in_run = 1'b0;
        end else begin
          stop_p = s_stop[c2]; p = c2 + 1;
        end
      end
    end
  endfunction

  task automatic do_reset();
    @(posedge pclk); #1;
    prst_n = 1'b0; i_start = 1'b0; i_stop = 1'b0; i_scl_in = 1'b1;
    @(posedge pclk); #1;
    prst_n = 1'b1;
  endtask

  // Drives stimulus arrays for n cycles and records outputs mid-cycle; no checking here.
  task automatic run_trace(input int n);
    obs_falls = 0; obs_rises = 0; obs_str = 0; obs_tmo = 0;
    build_expected(n);
    do_reset();
    for (int c = 0; c < n; c++) begin
      i_start  = s_start[c];
      i_stop   = s_stop[c];
      i_div    = DIV_W'(s_div[c]);
      i_scl_in = s_scl[c];
      @(negedge pclk);
      obs_v[c] = {o_scl, o_busy, o_fall, o_rise, o_stretch, o_tmo};
      obs_falls += int'(o_fall);
      obs_rises += int'(o_rise);
      obs_str   += int'(o_stretch);
      obs_tmo   += int'(o_tmo);
      @(posedge pclk); #1;
    end
    i_start = 1'b0; i_stop = 1'b0; i_scl_in = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    i_div = DIV_W'(10); i_start = 1'b1;
    @(posedge pclk); #1;
    i_start = 1'b0;
    repeat (7) @(posedge pclk);
    #1;
    n_cmp++;
    if (o_busy !== 1'b1) begin
      n_err++; $display("FAIL reset_prerun busy got %b exp 1", o_busy);
    end
    prst_n = 1'b0; i_scl_in = 1'b0;
    @(posedge pclk); #1;
    n_cmp++;
    if ({o_scl, o_busy, o_fall, o_rise, o_stretch, o_tmo} !== 6'b100000) begin
      n_err++; $display("FAIL reset_first_edge outs got %b exp 100000",
                        {o_scl, o_busy, o_fall, o_rise, o_stretch, o_tmo});
    end
    repeat (2) @(posedge pclk);
    #1;
    prst_n = 1'b1; i_scl_in = 1'b1;
    repeat (3) @(posedge pclk);
    #1;
    n_cmp++;
    if ({o_scl, o_busy, o_fall, o_rise, o_stretch, o_tmo} !== 6'b100000) begin
      n_err++; $display("FAIL reset_release outs got %b exp 100000",
                        {o_scl, o_busy, o_fall, o_rise, o_stretch, o_tmo});
    end
  endtask

  task automatic test_single_period();
    clear_stim(10);
    s_start[2] = 1'b1; s_stop[2] = 1'b1;
    run_trace(30);
    for (int c = 0; c < 30; c++) begin
      n_cmp++;
      if (obs_v[c] !== e_v[c]) begin
        n_err++; $display("FAIL single_period cyc %0d outs got %b exp %b", c, obs_v[c], e_v[c]);
      end
    end
    n_cmp++;
    if (obs_v[13][4] !== 1'b0 || obs_v[12] !== 6'b110000) begin
      n_err++; $display("FAIL single_period_end cyc12 got %b cyc13 got %b", obs_v[12], obs_v[13]);
    end
  endtask

  task automatic test_clamp_odd();
    int divs [3] = '{3, 7, 0};
    for (int t = 0; t < 3; t++) begin
      clear_stim(divs[t]);
      s_start[2] = 1'b1; s_stop[2] = 1'b1;
      run_trace(20);
      for (int c = 0; c < 20; c++) begin
        n_cmp++;
        if (obs_v[c] !== e_v[c]) begin
          n_err++; $display("FAIL clamp_odd div %0d cyc %0d outs got %b exp %b",
                            divs[t], c, obs_v[c], e_v[c]);
        end
      end
    end
  endtask

  task automatic test_div_change();
    clear_stim(10);
    for (int k = 5; k < MAXN; k++) s_div[k] = 20;
    s_start[2] = 1'b1; s_stop[15] = 1'b1;
    run_trace(45);
    for (int c = 0; c < 45; c++) begin
      n_cmp++;
      if (obs_v[c] !== e_v[c]) begin
        n_err++; $display("FAIL div_change cyc %0d outs got %b exp %b", c, obs_v[c], e_v[c]);
      end
    end
  endtask

  task automatic test_stretch();
    clear_stim(10);
    s_start[2] = 1'b1; s_stop[2] = 1'b1;
    for (int k = 8; k < 16; k++) s_scl[k] = 1'b0;
    run_trace(30);
    for (int c = 0; c < 30; c++) begin
      n_cmp++;
      if (obs_v[c] !== e_v[c]) begin
        n_err++; $display("FAIL stretch cyc %0d outs got %b exp %b", c, obs_v[c], e_v[c]);
      end
    end
    n_cmp++;
    if (obs_str != (STR_EN ? 8 : 0) || obs_tmo != 0) begin
      n_err++; $display("FAIL stretch_counts stretch %0d tmo %0d exp %0d 0",
                        obs_str, obs_tmo, STR_EN ? 8 : 0);
    end
  endtask

  task automatic test_timeout();
    clear_stim(10);
    s_start[2] = 1'b1; s_stop[2] = 1'b1;
    for (int k = 8; k < 46; k++) s_scl[k] = 1'b0;
    run_trace(50);
    for (int c = 0; c < 50; c++) begin
      n_cmp++;
      if (obs_v[c] !== e_v[c]) begin
        n_err++; $display("FAIL timeout cyc %0d outs got %b exp %b", c, obs_v[c], e_v[c]);
      end
    end
    n_cmp++;
    if (obs_tmo != (STR_EN ? 1 : 0)) begin
      n_err++; $display("FAIL timeout_pulses got %0d exp %0d", obs_tmo, STR_EN ? 1 : 0);
    end
  endtask

  task automatic test_continuous();
    clear_stim(8);
    s_start[2] = 1'b1; s_start[10] = 1'b1; s_start[20] = 1'b1;
    s_stop[24] = 1'b1;
    run_trace(40);
    for (int c = 0; c < 40; c++) begin
      n_cmp++;
      if (obs_v[c] !== e_v[c]) begin
        n_err++; $display("FAIL continuous cyc %0d outs got %b exp %b", c, obs_v[c], e_v[c]);
      end
    end
    n_cmp++;
    if (obs_falls != 3 || obs_rises != 3) begin
      n_err++; $display("FAIL continuous_strobes falls %0d rises %0d exp 3 3", obs_falls, obs_rises);
    end
  endtask

  task automatic test_random();
    int burst;
    for (int it = 0; it < 4; it++) begin
      clear_stim($urandom_range(0, 24));
      burst = 0;
      for (int c = 0; c < 300; c++) begin
        if (c > 0) s_div[c] = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 24) : s_div[c-1];
        s_start[c] = ($urandom_range(0, 5) == 0);
        s_stop[c]  = ($urandom_range(0, 11) == 0);
        if (burst > 0) begin
          s_scl[c] = 1'b0; burst--;
        end else if ($urandom_range(0, 15) == 0) begin
          burst = $urandom_range(1, 20);
        end
      end
      run_trace(300);
      for (int c = 0; c < 300; c++) begin
        n_cmp++;
        if (obs_v[c] !== e_v[c]) begin
          n_err++; $display("FAIL random it %0d cyc %0d outs got %b exp %b", it, c, obs_v[c], e_v[c]);
        end
      end
    end
  endtask

  initial begin
    prst_n = 1'b0; i_div = '0; i_start = 1'b0; i_stop = 1'b0; i_scl_in = 1'b1;
    test_reset();
    test_single_period();
    test_clamp_odd();
    test_div_change();
    test_stretch();
    test_timeout();
    test_continuous();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
